// File: rtl/xor_reduce_ctrl_pkg.sv
// Shared constants for the XOR-reduce checksum sequencer: state encoding
// and the default accumulator seed.
package xor_reduce_ctrl_pkg;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ACCUM = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [15:0] DEF_SEED = 16'h0000;
endpackage

// File: rtl/xor_reduce_ctrl_if.sv
// Burst handshake bundle between an issuing stage (master) and the
// checksum sequencer (slave).
interface xor_reduce_ctrl_if #(parameter int LEN_W = 8);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             inValid;
  logic [15:0]      inData;
  logic             inReady;
  logic             busy;
  logic             done;
  logic [15:0]      result;

  modport master (output start, len, abort, inValid, inData,
                  input  inReady, busy, done, result);
  modport slave  (input  start, len, abort, inValid, inData,
                  output inReady, busy, done, result);
endinterface

// File: rtl/xor_16bit.sv
// Existing 16-bit XOR datapath reused by the checksum sequencer.
module xor_16bit (
  input  logic [15:0] InA,
  input  logic [15:0] InB,
  output logic [15:0] Out
);
  assign Out = InA ^ InB;
endmodule

// File: rtl/xor_reduce_ctrl.sv
// XOR-reduce checksum sequencer: folds a burst of 16-bit words into one
// checksum through a single xor_16bit instance.
// Build option XOR_REDUCE_ROTATE_EN: rotate acc left by one before each
// fold, making the checksum order-sensitive.
module xor_reduce_ctrl
  import xor_reduce_ctrl_pkg::*;
#(
  parameter int          LEN_W = 8,
  parameter logic [15:0] SEED  = DEF_SEED
) (
  input logic clk,
  input logic rst_n,
  xor_reduce_ctrl_if.slave bus
);

  logic [1:0]       state, stateNxt;
  logic [15:0]      acc, accNxt;
  logic [LEN_W-1:0] cnt, cntNxt;
  logic [15:0]      result, resultNxt;
  logic [15:0]      accRot, foldOut;
  logic             beat;

`ifdef XOR_REDUCE_ROTATE_EN
  assign accRot = {acc[14:0], acc[15]};
`else
  assign accRot = acc;
`endif

  xor_16bit uXor (
    .InA (accRot),
    .InB (bus.inData),
    .Out (foldOut)
  );

  assign bus.inReady = (state == ST_ACCUM);
  assign bus.busy    = (state == ST_ACCUM) || (state == ST_DONE);
  assign bus.done    = (state == ST_DONE);
  assign bus.result  = result;
  assign beat        = bus.inValid && bus.inReady;

  // State, accumulator, counter and result registers with sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= SEED;
      cnt    <= '0;
      result <= 16'h0000;
    end else begin
      state  <= stateNxt;
      acc    <= accNxt;
      cnt    <= cntNxt;
      result <= resultNxt;
    end
  end

  // Next-state logic; abort beats a coincident final beat, and the
  // counter only decrements on a beat and never below zero
  always_comb begin
    stateNxt  = state;
    accNxt    = acc;
    cntNxt    = cnt;
    resultNxt = result;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accNxt = SEED;
          if (bus.len != '0) begin
            stateNxt = ST_ACCUM;
            cntNxt   = bus.len;
          end else begin
            stateNxt = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          stateNxt = ST_IDLE;
          cntNxt   = '0;
        end else if (beat) begin
          accNxt = foldOut;
          if (cnt != '0) cntNxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) stateNxt = ST_DONE;
        end
      end
      ST_DONE: begin
        resultNxt = acc;
        stateNxt  = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

endmodule
